// File: rtl/cr_su_agg_pkg.sv
// cr_su_agg_pkg: shared state encoding, record type and sizing helpers for the aggregator
package cr_su_agg_pkg;
  typedef enum logic {SU_AGG_IDLE, SU_AGG_SEND} su_agg_state_e;
  localparam int SU_AGG_REC_W = 128;
  typedef logic [SU_AGG_REC_W-1:0] su_agg_rec_t;
  function automatic int beats(input int rec_w, input int dp_w);
    return rec_w / dp_w;
  endfunction
  function automatic int id_w(input int n_ch);
    return n_ch > 1 ? $clog2(n_ch) : 1;
  endfunction
endpackage

// File: rtl/cr_su_agg_fifo.sv
// cr_su_agg_fifo: per-channel record FIFO with registered not-full and combinational head
module cr_su_agg_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         nfull,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic nfull_q, nfull_d;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    nfull_d = cnt_d != (AW+1)'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      nfull_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      nfull_q <= nfull_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign nfull = nfull_q;
  assign empty = cnt_q == '0;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/cr_su_agg.sv
// cr_su_agg: multi-channel scheduler-update aggregator with round-robin serialiser and record counters
module cr_su_agg
  import cr_su_agg_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int REC_W = 128,
  parameter int DP_W = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 32,
  localparam int ID_W = id_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       su_in_valid,
  input  logic [N_CH*REC_W-1:0] su_in_data,
  output logic [N_CH-1:0]       su_ready,
  input  logic                  su_ob_in_tready,
  output logic                  su_ob_out_tvalid,
  output logic [DP_W-1:0]       su_ob_out_tdata,
  output logic                  su_ob_out_tlast,
  output logic                  su_ob_out_sop,
  output logic [ID_W-1:0]       su_ob_out_tid,
  input  logic                  cnt_snap_stb,
  output logic [N_CH*CNT_W-1:0] su_cnt,
  output logic                  su_agg_cnt_stb
);
  localparam int BEATS = beats(REC_W, DP_W);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  su_agg_state_e state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d, rr_q, rr_d, sel, idx;
  logic [BW-1:0] beat_q, beat_d;
  logic [REC_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] live_q [N_CH];
  logic [CNT_W-1:0] live_d [N_CH];
  logic [N_CH*CNT_W-1:0] cnt_q, cnt_d;
  logic stb_q;
  logic [N_CH-1:0] nfull, empty, pop;
  logic [REC_W-1:0] head [N_CH];
  logic fire, last_fire, found, load;
  int start;
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    cr_su_agg_fifo #(.DEPTH(FIFO_DEPTH), .W(REC_W)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(su_in_valid[k] & nfull[k]),
      .din(su_in_data[k*REC_W +: REC_W]),
      .pop(pop[k]),
      .nfull(nfull[k]),
      .empty(empty[k]),
      .head(head[k])
    );
  end
  always_comb begin
    fire = state_q == SU_AGG_SEND && su_ob_in_tready;
    last_fire = fire && beat_q == BW'(BEATS - 1);
    start = last_fire ? (int'(grant_q) + 1) % N_CH : int'(rr_q);
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = ID_W'((start + i) % N_CH);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    load = found && (state_q == SU_AGG_IDLE || last_fire);
    pop = load ? N_CH'(1) << sel : '0;
    state_d = load ? SU_AGG_SEND : last_fire ? SU_AGG_IDLE : state_q;
    grant_d = load ? sel : grant_q;
    rr_d = last_fire ? ID_W'(start) : rr_q;
    beat_d = load ? '0 : fire ? beat_q + 1'b1 : beat_q;
    shreg_d = load ? head[sel] : fire ? shreg_q >> DP_W : shreg_q;
  end
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      live_d[i] = last_fire && grant_q == ID_W'(i) && live_q[i] != '1 ? live_q[i] + 1'b1 : live_q[i];
      cnt_d[i*CNT_W +: CNT_W] = cnt_snap_stb ? live_d[i] : cnt_q[i*CNT_W +: CNT_W];
      live_d[i] = cnt_snap_stb ? '0 : live_d[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SU_AGG_IDLE;
      grant_q <= '0;
      rr_q <= '0;
      beat_q <= '0;
      shreg_q <= '0;
      live_q <= '{default: '0};
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      beat_q <= beat_d;
      shreg_q <= shreg_d;
      live_q <= live_d;
      cnt_q <= cnt_d;
      stb_q <= cnt_snap_stb;
    end
  end
  assign su_ready = nfull;
  assign su_ob_out_tvalid = state_q == SU_AGG_SEND;
  assign su_ob_out_tdata = shreg_q[DP_W-1:0];
  assign su_ob_out_tlast = su_ob_out_tvalid && beat_q == BW'(BEATS - 1);
  assign su_ob_out_sop = su_ob_out_tvalid && beat_q == '0;
  assign su_ob_out_tid = grant_q;
  assign su_cnt = cnt_q;
  assign su_agg_cnt_stb = stb_q;
endmodule

// File: tb/tb_cr_su_agg.sv
// tb_cr_su_agg: randomized and directed scoreboard bench for the scheduler-update aggregator
module tb_cr_su_agg;
  localparam int N = 4;
  localparam int RW = 128;
  localparam int DW = 64;
  localparam int DEPTH = 4;
  localparam int CW = 32;
  localparam int BEATS = RW / DW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] valid = '0;
  logic [N*RW-1:0] data = '0;
  logic [N-1:0] ready;
  logic tready = 1'b0;
  logic tvalid, tlast, sop, stb;
  logic [DW-1:0] tdata;
  logic [1:0] tid;
  logic snap = 1'b0;
  logic [N*CW-1:0] su_cnt;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_edge = 0;
  logic [RW-1:0] exp_q [N][$];
  int ord_q[$];
  logic [N*CW-1:0] snap_q[$];
  int unsigned model [N];
  logic [RW-1:0] asm_rec;
  int bidx = 0;
  logic [1:0] cur_tid = '0;
  int last_tid = 0;
  int fire_cnt = 0;
  int sop_cnt = 0;
  int sop_edge = 0;
  int rec_cnt = 0;
  logic pstall = 1'b0;
  logic [67:0] pbeat = '0;
  logic prev_snap = 1'b0;
  logic [N-1:0] done_ch;
  logic [N*CW-1:0] exp_snap;
  cr_su_agg #(.N_CH(N), .REC_W(RW), .DP_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .su_in_valid(valid),
    .su_in_data(data),
    .su_ready(ready),
    .su_ob_in_tready(tready),
    .su_ob_out_tvalid(tvalid),
    .su_ob_out_tdata(tdata),
    .su_ob_out_tlast(tlast),
    .su_ob_out_sop(sop),
    .su_ob_out_tid(tid),
    .cnt_snap_stb(snap),
    .su_cnt(su_cnt),
    .su_agg_cnt_stb(stb)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic logic [RW-1:0] rand_rec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += exp_q[k].size();
    return s;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (pstall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_beat", {tid, tlast, sop, tdata}, pbeat);
      end
      pstall = tvalid && !tready;
      pbeat = {tid, tlast, sop, tdata};
      done_ch = '0;
      if (tvalid && tready) begin
        fire_cnt++;
        chk("sop_pos", sop, bidx == 0);
        chk("tlast_pos", tlast, bidx == BEATS - 1);
        if (bidx == 0) begin
          cur_tid = tid;
          sop_edge = cyc + 1;
          sop_cnt++;
        end else chk("tid_in_record", tid, cur_tid);
        asm_rec[bidx*DW +: DW] = tdata;
        if (bidx == BEATS - 1) begin
          bidx = 0;
          rec_cnt++;
          if (exp_q[cur_tid].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_record: got ch%0d data %h expected none", cur_tid, asm_rec);
          end else chk("rec_data", asm_rec, exp_q[cur_tid].pop_front());
          if (ord_q.size() != 0) chk("rr_order", cur_tid, ord_q.pop_front());
          last_tid = cur_tid;
          done_ch[cur_tid] = 1'b1;
        end else bidx++;
      end
      chk("agg_stb", stb, prev_snap);
      if (stb && snap_q.size() != 0) chk("snap_value", su_cnt, snap_q.pop_front());
      for (int k = 0; k < N; k++) begin
        exp_snap[k*CW +: CW] = (done_ch[k] && model[k] != '1) ? model[k] + 1 : model[k];
        model[k] = snap ? 0 : exp_snap[k*CW +: CW];
      end
      if (snap) snap_q.push_back(exp_snap);
      prev_snap = snap;
    end
  end
  task automatic push_mask(input logic [N-1:0] m, input bit rnd);
    logic [N-1:0] pend;
    pend = m;
    for (int k = 0; k < N; k++) if (m[k] && rnd) data[k*RW +: RW] = rand_rec();
    valid = valid | m;
    for (int c = 0; c < 50 && pend != 0; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (pend[k] && ready[k]) begin
          exp_q[k].push_back(data[k*RW +: RW]);
          pend[k] = 1'b0;
          acc_edge = cyc + 1;
        end
      end
      @(posedge clk);
      #1;
      valid = valid & ~(m & ~pend);
    end
    if (pend != 0) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got pending %b expected 0", pend);
      valid = valid & ~m;
    end
  endtask
  task automatic drain();
    tready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (pending() == 0 && !tvalid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", pending(), 0);
  endtask
  task automatic pulse_snap();
    snap = 1'b1;
    @(posedge clk);
    #1;
    snap = 1'b0;
  endtask
  initial begin
    logic [N-1:0] acc;
    int n, s0, f0, rc0;
    logic [RW-1:0] rec;
    for (int k = 0; k < N; k++) model[k] = 0;
    valid = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_flags", {tlast, sop, tid, stb}, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_cnt", su_cnt, 0);
    valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_release", ready, 4'hF);
    tready = 1'b1;
    rec = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    data[2*RW +: RW] = rec;
    s0 = sop_cnt;
    push_mask(4'b0100, 1'b0);
    for (int c = 0; c < 10 && sop_cnt == s0; c++) begin
      @(posedge clk);
      #1;
    end
    chk("first_beat_latency", sop_edge - acc_edge, 2);
    drain();
    chk("single_tid", last_tid, 2);
    tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_mask(4'hF, 1'b1);
    push_mask(4'hF, 1'b1);
    for (int r = 0; r < 2 * N; r++) ord_q.push_back((last_tid + 1 + r) % N);
    repeat (2) @(posedge clk);
    #1;
    tready = 1'b1;
    f0 = fire_cnt;
    repeat (2 * N * BEATS) @(posedge clk);
    #1;
    chk("no_bubble", fire_cnt - f0, 2 * N * BEATS);
    chk("rr_all_seen", ord_q.size(), 0);
    drain();
    fork
      begin
        push_mask(4'b0101, 1'b1);
        push_mask(4'b1010, 1'b1);
        push_mask(4'b0001, 1'b1);
      end
      begin
        repeat (30) begin
          @(posedge clk);
          #1;
          tready = ~tready;
        end
      end
    join
    drain();
    tready = 1'b0;
    n = 0;
    valid[0] = 1'b1;
    data[0 +: RW] = rand_rec();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!ready[0]) break;
      exp_q[0].push_back(data[0 +: RW]);
      n++;
      @(posedge clk);
      #1;
      data[0 +: RW] = rand_rec();
    end
    chk("full_after_depth_plus_one", n, DEPTH + 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("held_while_full", ready[0], 0);
    end
    rc0 = rec_cnt;
    @(posedge clk);
    #1;
    tready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready[0]) begin
        n = 1;
        break;
      end
    end
    chk("held_accepted", n, 1);
    chk("held_after_pop", rec_cnt > rc0, 1);
    if (n == 1) exp_q[0].push_back(data[0 +: RW]);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    drain();
    pulse_snap();
    repeat (3) push_mask(4'b0010, 1'b1);
    drain();
    push_mask(4'b0010, 1'b1);
    for (int c = 0; c < 20 && !(tvalid && tlast && tid == 2'd1); c++) begin
      @(posedge clk);
      #1;
    end
    pulse_snap();
    chk("snap_ch1_with_tlast", su_cnt[CW +: CW], 4);
    chk("snap_others", {su_cnt[3*CW +: CW], su_cnt[2*CW +: CW], su_cnt[0 +: CW]}, 0);
    chk("snap_stb_pulse", stb, 1);
    repeat (3) @(posedge clk);
    #1;
    pulse_snap();
    chk("snap_idle_zero", su_cnt, 0);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc = valid & ready;
      for (int k = 0; k < N; k++) if (acc[k]) exp_q[k].push_back(data[k*RW +: RW]);
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] || !valid[k]) begin
          valid[k] = $urandom_range(0, 99) < 40;
          data[k*RW +: RW] = rand_rec();
        end
      end
      tready = $urandom_range(0, 3) != 0;
      snap = i == 700 || i == 701 || $urandom_range(0, 59) == 0;
    end
    @(negedge clk);
    acc = valid & ready;
    for (int k = 0; k < N; k++) if (acc[k]) exp_q[k].push_back(data[k*RW +: RW]);
    @(posedge clk);
    #1;
    valid = '0;
    snap = 1'b0;
    drain();
    pulse_snap();
    repeat (3) @(posedge clk);
    #1;
    chk("snap_queue_empty", snap_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
